// File: rtl/seq_playback_pkg.sv
// Shared types for the colour-sequence playback block: FSM states, colour codes
// and the one-hot LED encoding helper.
package seq_playback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef logic [1:0] colour_t;

  localparam colour_t RED    = 2'd0;
  localparam colour_t GREEN  = 2'd1;
  localparam colour_t BLUE   = 2'd2;
  localparam colour_t YELLOW = 2'd3;

  function automatic logic [3:0] colour_onehot(input colour_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/seq_playback_step_timer.sv
// Down-counting step timer: loads a cycle count on state entry and flags zero
// when the current phase has run its full length.
module step_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/seq_playback.sv
// Stores a sequence of 2-bit colour codes and plays it back on a one-hot LED,
// each step lit for ON_CYCLES then dark for OFF_CYCLES, ending with a done pulse.
module seq_playback
  import seq_playback_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ON_CYCLES  = 8,
  parameter int OFF_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mem_load,
  input  logic [1:0]                   mem_load_val,
  input  logic                         mem_clr,
  input  logic                         en_play,
  input  logic [3:0]                   level,
  output logic [3:0]                   led,
  output logic                         busy,
  output logic                         complete_play,
  output logic [$clog2(DEPTH+1)-1:0]   mem_count
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = ((CW > 4) ? CW : 4) + 1;

  colour_t       r_mem [DEPTH];
  logic [CW-1:0] r_count;
  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_len;
  logic [3:0]    r_led;
  logic          r_busy;
  logic          r_done;

  logic          w_full;
  logic [RW-1:0] w_req;
  logic [CW-1:0] w_len;
  logic          w_last;
  logic          w_tzero;
  logic          w_tload;
  logic [TW-1:0] w_tval;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_req  = RW'(level) + RW'(1);
  assign w_len  = (w_req > RW'(r_count)) ? r_count : w_req[CW-1:0];
  assign w_last = ((CW'(r_idx) + CW'(1)) == r_len);

  // Write port runs independently of playback; clear wins over load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (mem_clr) begin
      r_count <= '0;
    end else if (mem_load && !w_full) begin
      r_count <= r_count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !mem_clr && mem_load && !w_full) begin
      r_mem[r_count[IW-1:0]] <= mem_load_val;
    end
  end

  always_comb begin
    w_tload = 1'b0;
    w_tval  = '0;
    case (r_state)
      ST_IDLE: if (en_play && (w_len != '0)) begin
        w_tload = 1'b1;
        w_tval  = TW'(ON_CYCLES - 1);
      end
      ST_ON: if (w_tzero) begin
        w_tload = 1'b1;
        w_tval  = TW'(OFF_CYCLES - 1);
      end
      ST_OFF: if (w_tzero && !w_last) begin
        w_tload = 1'b1;
        w_tval  = TW'(ON_CYCLES - 1);
      end
      default: ;
    endcase
  end

  step_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_tload),
    .load_val (w_tval),
    .zero     (w_tzero)
  );

  // Playback length is latched at start, so later loads/clears never change it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en_play) begin
            r_len  <= w_len;
            r_idx  <= '0;
            r_busy <= 1'b1;
            if (w_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ON;
              r_led   <= colour_onehot(r_mem[0]);
            end
          end
        end
        ST_ON: begin
          if (w_tzero) begin
            r_state <= ST_OFF;
            r_led   <= '0;
          end
        end
        ST_OFF: begin
          if (w_tzero) begin
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ON;
              r_idx   <= r_idx + IW'(1);
              r_led   <= colour_onehot(r_mem[r_idx + IW'(1)]);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_led   <= '0;
        end
      endcase
    end
  end

  assign led           = r_led;
  assign busy          = r_busy;
  assign complete_play = r_done;
  assign mem_count     = r_count;

endmodule

// File: tb/tb_seq_playback.sv
// Self-checking bench for seq_playback: table-driven write-port vectors, directed
// playback sequences and randomized playbacks against a timeline reference model.
module tb_seq_playback;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_load;
  logic [1:0] mem_load_val;
  logic       mem_clr;
  logic       en_play;
  logic [3:0] level;
  logic [3:0] led;
  logic       busy;
  logic       complete_play;
  logic [4:0] mem_count;

  int n_checks = 0;
  int n_errors = 0;

  int         m_cnt;
  logic [1:0] m_mem [16];

  typedef struct {
    bit         ld;
    logic [1:0] val;
    bit         clr;
    int         exp_cnt;
  } wvec_t;

  always #5 clk = ~clk;

  seq_playback dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_load      (mem_load),
    .mem_load_val  (mem_load_val),
    .mem_clr       (mem_clr),
    .en_play       (en_play),
    .level         (level),
    .led           (led),
    .busy          (busy),
    .complete_play (complete_play),
    .mem_count     (mem_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_op(input bit ld, input logic [1:0] v, input bit clr);
    mem_load     = ld;
    mem_load_val = v;
    mem_clr      = clr;
    tick();
    mem_load = 1'b0;
    mem_clr  = 1'b0;
    if (clr) m_cnt = 0;
    else if (ld && m_cnt < 16) begin
      m_mem[m_cnt] = v;
      m_cnt++;
    end
  endtask

  // Expected timeline: each step is 8 lit cycles then 4 dark, then one DONE cycle.
  task automatic play(input int lvl, input int en2_at, input int clr_at, input string tag);
    int len, total, led_bad, busy_bad, done_cnt, done_at, first_bad;
    logic [3:0] exp_led;
    logic [3:0] lv;
    len       = (lvl + 1 < m_cnt) ? lvl + 1 : m_cnt;
    total     = 1 + len * 12;
    led_bad   = 0;
    busy_bad  = 0;
    done_cnt  = 0;
    done_at   = -1;
    first_bad = -1;
    lv        = lvl[3:0];
    for (int k = 1; k <= total + 1; k++) begin
      en_play = (k == 1) || (k == en2_at);
      level   = (k == 1) ? lv : 4'hF;
      mem_clr = (k == clr_at);
      tick();
      if (k == clr_at) m_cnt = 0;
      if (k <= len * 12 && ((k - 1) % 12) < 8) exp_led = 4'b0001 << m_mem[(k - 1) / 12];
      else exp_led = 4'b0000;
      if (led !== exp_led) begin
        led_bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (busy !== (k <= total)) busy_bad++;
      if (complete_play === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
    end
    en_play = 1'b0;
    mem_clr = 1'b0;
    check({tag, "_led_bad_cycles(first=", $sformatf("%0d", first_bad), ")"}, led_bad, 0);
    check({tag, "_busy_bad_cycles"}, busy_bad, 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_done_cycle"}, done_at, total);
  endtask

  initial begin
    wvec_t tbl [8];
    int    dcnt, bcnt, n, lvl, e2, ca;

    rst_n        = 1'b0;
    mem_load     = 1'b0;
    mem_load_val = 2'd0;
    mem_clr      = 1'b0;
    en_play      = 1'b0;
    level        = 4'd0;
    m_cnt        = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 2'd0;

    tick();
    tick();
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    check("rst_done", complete_play, 0);
    check("rst_count", mem_count, 0);
    rst_n = 1'b1;
    tick();

    tbl[0] = '{1'b0, 2'd0, 1'b1, 0};
    tbl[1] = '{1'b1, 2'd2, 1'b0, 1};
    tbl[2] = '{1'b1, 2'd1, 1'b0, 2};
    tbl[3] = '{1'b1, 2'd3, 1'b1, 0};
    tbl[4] = '{1'b1, 2'd2, 1'b0, 1};
    tbl[5] = '{1'b1, 2'd0, 1'b0, 2};
    tbl[6] = '{1'b1, 2'd3, 1'b0, 3};
    tbl[7] = '{1'b0, 2'd1, 1'b0, 3};
    for (int i = 0; i < 8; i++) begin
      write_op(tbl[i].ld, tbl[i].val, tbl[i].clr);
      check($sformatf("tbl%0d_count", i), mem_count, tbl[i].exp_cnt);
    end

    play(2, 0, 0, "seq_203");
    play(9, 20, 0, "len3_en_again");
    play(1, 0, 15, "clr_midplay");
    check("clr_midplay_count", mem_count, 0);
    play(5, 0, 0, "empty_play");

    for (int i = 0; i < 17; i++) write_op(1'b1, 2'($urandom_range(0, 3)), 1'b0);
    check("full_count", mem_count, 16);
    play(15, 0, 0, "full_play");

    write_op(1'b0, 2'd0, 1'b1);
    write_op(1'b1, 2'd1, 1'b0);
    write_op(1'b1, 2'd2, 1'b0);
    write_op(1'b1, 2'd3, 1'b0);
    en_play = 1'b1;
    level   = 4'd2;
    tick();
    en_play = 1'b0;
    for (int k = 2; k <= 14; k++) tick();
    check("pre_rst_led_step2", led, 4);
    rst_n = 1'b0;
    tick();
    m_cnt = 0;
    check("midrst_led", led, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", complete_play, 0);
    check("midrst_count", mem_count, 0);
    rst_n = 1'b1;
    dcnt  = 0;
    bcnt  = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (complete_play !== 1'b0) dcnt++;
      if (busy !== 1'b0) bcnt++;
    end
    check("midrst_no_done_pulse", dcnt, 0);
    check("midrst_stays_idle", bcnt, 0);

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) write_op(1'b0, 2'd0, 1'b1);
      n = $urandom_range(0, 20);
      for (int j = 0; j < n; j++) write_op(1'b1, 2'($urandom_range(0, 3)), 1'b0);
      check($sformatf("rnd%0d_count", it), mem_count, m_cnt);
      lvl = $urandom_range(0, 15);
      e2  = $urandom_range(2, 40);
      ca  = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : 0;
      play(lvl, e2, ca, $sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_count_after", it), mem_count, m_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
